// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Parses framed load packets arriving from a UART receiver and writes the
//   carried 32-bit words into a word-addressed memory port. Each complete
//   frame is answered with a one-byte ACK (good checksum) or NAK (bad one).
//
//   Frame: SYNC, ADDR_LO, ADDR_HI, COUNT, COUNT*4 data bytes (LE), CHK.
//   The 8-bit sum of every byte after SYNC, CHK included, must be zero.
//
// Ports
//   clk_50m, rst_n          clock, synchronous active-low reset
//   rx_rdy, rx_data         receiver byte-available flag and byte
//   rx_rdy_clr              one-cycle acknowledge of a captured byte
//   tx_din, tx_wr_en        response byte and one-cycle send request
//   tx_busy                 transmitter busy; response waits for it to drop
//   mem_we/addr/wdata       one-cycle word write
//   busy                    frame in progress
//   frame_ok, frame_err     one-cycle frame status pulses
module uart_mem_loader #(
    parameter int           ADDR_W      = 10,
    parameter logic [7:0]   SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]   ACK_BYTE    = 8'h06,
    parameter logic [7:0]   NAK_BYTE    = 8'h15,
    parameter int           TIMEOUT_CYC = 1000000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, COUNT, DATA, CHK, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              rx_rdy_clr_q, rx_rdy_clr_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;

    logic              cap;
    logic              in_frame;
    logic [7:0]        sum_add;
    logic [31:0]       word_shift;

    // rx_rdy is ignored while the previous acknowledge is still out, so a
    // receiver that drops rx_rdy one cycle late is not captured twice.
    assign cap        = rx_rdy && !rx_rdy_clr_q && (state_q != RESP);
    assign in_frame   = (state_q != IDLE) && (state_q != RESP);
    assign sum_add    = sum_q + rx_data;
    assign word_shift = {rx_data, word_q[31:8]};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        rx_rdy_clr_d = cap;
        tx_din_d     = tx_din_q;
        tx_wr_en_d   = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;

        if (in_frame)
            tmo_d = cap ? '0 : tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cap && rx_data == SYNC_BYTE) begin
                    state_d = ADDR_LO;
                    sum_d   = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            ADDR_LO: if (cap) begin
                addr_d[7:0] = rx_data;
                sum_d       = sum_add;
                state_d     = ADDR_HI;
            end
            ADDR_HI: if (cap) begin
                addr_d[15:8] = rx_data;
                sum_d        = sum_add;
                state_d      = COUNT;
            end
            COUNT: if (cap) begin
                cnt_d   = rx_data;
                sum_d   = sum_add;
                state_d = (rx_data == 8'd0) ? CHK : DATA;
            end
            DATA: if (cap) begin
                sum_d  = sum_add;
                word_d = word_shift;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word_shift;
                    mem_addr_d  = addr_q[ADDR_W-1:0];
                    // Only the low ADDR_W bits reach the port, so this
                    // wraps modulo 2^ADDR_W as seen by memory.
                    addr_d      = addr_q + 16'd1;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1)
                        state_d = CHK;
                end
            end
            CHK: if (cap) begin
                sum_d   = sum_add;
                state_d = RESP;
                if (sum_add == 8'd0) begin
                    frame_ok_d = 1'b1;
                    tx_din_d   = ACK_BYTE;
                end else begin
                    frame_err_d = 1'b1;
                    tx_din_d    = NAK_BYTE;
                end
            end
            RESP: begin
                if (!tx_busy) begin
                    tx_wr_en_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry loses to a byte arriving on the same edge.
        if (in_frame && !cap && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end

        // Held through the tx_wr_en cycle so busy drops the cycle after it.
        busy_d = (state_d != IDLE) || tx_wr_en_d;
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            rx_rdy_clr_q <= 1'b0;
            tx_din_q     <= '0;
            tx_wr_en_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            tx_din_q     <= tx_din_d;
            tx_wr_en_q   <= tx_wr_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign tx_din     = tx_din_q;
    assign tx_wr_en   = tx_wr_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: feeds frames through a model of the
// receiver handshake and checks writes, status pulses and responses.
module tb_uart_mem_loader;

    localparam int ADDR_W = 10;
    localparam int TMO    = 40;

    logic              clk_50m = 1'b0;
    logic              rst_n;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_rdy_clr;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              tx_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              frame_ok;
    logic              frame_err;

    uart_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr),
        .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #10 clk_50m = ~clk_50m;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors, sampled mid-cycle.
    int               we_cnt = 0, tx_cnt = 0, ok_cnt = 0, err_cnt = 0, clr_cnt = 0;
    logic [31:0]      w_addr [$];
    logic [31:0]      w_data [$];
    logic [7:0]       last_tx = 8'h00;
    logic             busy_seen = 1'b0;

    always @(negedge clk_50m) begin
        if (mem_we) begin
            we_cnt++;
            w_addr.push_back(32'(mem_addr));
            w_data.push_back(mem_wdata);
        end
        if (tx_wr_en) begin tx_cnt++; last_tx = tx_din; end
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (rx_rdy_clr) clr_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    logic [7:0] fr [$];
    int we0, tx0, ok0, err0, clr0;

    task automatic snap();
        we0 = we_cnt; tx0 = tx_cnt; ok0 = ok_cnt; err0 = err_cnt; clr0 = clr_cnt;
        w_addr.delete(); w_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(negedge clk_50m);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk_50m); #1;
            if (rx_rdy_clr) got = 1;
        end
        rx_rdy = 1'b0;
        if (!got) chk("rx_handshake", 32'(got), 32'd1);
    endtask

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 60 && tx_cnt == tx0; i++) @(negedge clk_50m);
        repeat (2) @(negedge clk_50m);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_clr"},   32'(rx_rdy_clr), 0);
        chk({tag, "_txen"},  32'(tx_wr_en), 0);
        chk({tag, "_txdin"}, 32'(tx_din), 0);
        chk({tag, "_we"},    32'(mem_we), 0);
        chk({tag, "_addr"},  32'(mem_addr), 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_ok"},    32'(frame_ok), 0);
        chk({tag, "_err"},   32'(frame_err), 0);
    endtask

    int waited;

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 chk_idle_outputs("reset");
        @(negedge clk_50m) rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);

        // Good frame
        snap();
        fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDB};
        send_frame(); wait_resp();
        chk("good_we_n",   32'(we_cnt - we0), 1);
        chk("good_addr",   w_addr.size() > 0 ? w_addr[0] : 32'hDEAD, 32'h010);
        chk("good_wdata",  w_data.size() > 0 ? w_data[0] : 32'hDEAD, 32'h12345678);
        chk("good_ok",     32'(ok_cnt - ok0), 1);
        chk("good_err",    32'(err_cnt - err0), 0);
        chk("good_tx_n",   32'(tx_cnt - tx0), 1);
        chk("good_tx_din", 32'(last_tx), 32'h06);
        chk("good_busy",   32'(busy), 0);

        // Bad checksum
        snap();
        fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
        send_frame(); wait_resp();
        chk("bad_we_n",   32'(we_cnt - we0), 1);
        chk("bad_err",    32'(err_cnt - err0), 1);
        chk("bad_ok",     32'(ok_cnt - ok0), 0);
        chk("bad_tx_din", 32'(last_tx), 32'h15);

        // Garbage, then empty frame
        snap();
        busy_seen = 1'b0;
        fr = '{8'h00, 8'hFF};
        send_frame();
        repeat (3) @(negedge clk_50m);
        chk("garb_clr_n", 32'(clr_cnt - clr0), 2);
        chk("garb_busy",  32'(busy_seen), 0);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(); wait_resp();
        chk("empty_we_n",   32'(we_cnt - we0), 0);
        chk("empty_tx_n",   32'(tx_cnt - tx0), 1);
        chk("empty_tx_din", 32'(last_tx), 32'h06);

        // Address wrap
        snap();
        fr = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
               8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        send_frame(); wait_resp();
        chk("wrap_we_n",  32'(we_cnt - we0), 2);
        chk("wrap_addr0", w_addr.size() > 0 ? w_addr[0] : 32'hDEAD, 32'h3FF);
        chk("wrap_data0", w_data.size() > 0 ? w_data[0] : 32'hDEAD, 32'hAABBCCDD);
        chk("wrap_addr1", w_addr.size() > 1 ? w_addr[1] : 32'hDEAD, 32'h000);
        chk("wrap_data1", w_data.size() > 1 ? w_data[1] : 32'hDEAD, 32'h11223344);
        chk("wrap_tx_din", 32'(last_tx), 32'h06);

        // Timeout
        snap();
        fr = '{8'hA5, 8'h10};
        send_frame();
        waited = 0;
        while (err_cnt == err0 && waited < 200) begin
            @(negedge clk_50m); waited++;
        end
        chk("tmo_err",  32'(err_cnt - err0), 1);
        chk("tmo_time", 32'(waited >= TMO - 3 && waited <= TMO + 3), 1);
        repeat (2) @(negedge clk_50m);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_tx_n", 32'(tx_cnt - tx0), 0);
        snap();
        fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDB};
        send_frame(); wait_resp();
        chk("post_tmo_we",  32'(we_cnt - we0), 1);
        chk("post_tmo_ok",  32'(ok_cnt - ok0), 1);
        chk("post_tmo_ack", 32'(last_tx), 32'h06);

        // Reset mid-DATA
        snap();
        fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
        send_frame();
        @(negedge clk_50m) rst_n = 1'b0;
        @(posedge clk_50m); #1 chk_idle_outputs("midrst");
        @(negedge clk_50m) rst_n = 1'b1;
        repeat (10) @(negedge clk_50m);
        chk("midrst_we_n", 32'(we_cnt - we0), 0);
        chk("midrst_tx_n", 32'(tx_cnt - tx0), 0);
        chk("midrst_busy", 32'(busy), 0);

        // Response held off by tx_busy
        snap();
        tx_busy = 1'b1;
        fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDB};
        send_frame();
        repeat (10) @(negedge clk_50m);
        chk("hold_tx_n", 32'(tx_cnt - tx0), 0);
        chk("hold_busy", 32'(busy), 1);
        tx_busy = 1'b0;
        @(posedge clk_50m); #1;
        chk("hold_txen",   32'(tx_wr_en), 1);
        chk("hold_tx_din", 32'(tx_din), 32'h06);
        @(posedge clk_50m); #1;
        chk("hold_txen_1cyc", 32'(tx_wr_en), 0);
        chk("hold_busy_fall", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
